// File: rtl/psc_trigger_pkg.sv
// Shared types and constants for the PSC trigger bank.
// Channel state encoding and configuration register selects live here.
package psc_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } state_e;

  localparam logic CFG_DELAY = 1'b0;
  localparam logic CFG_WIDTH = 1'b1;

  // Channel-index width, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psc_trigger_bank_if.sv
// Configuration write port of the PSC trigger bank.
// The host drives it through the master modport; the bank listens on slave.
interface psc_trigger_bank_if
  import psc_trigger_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
);
  localparam int ADDR_W = addr_w(CHANNELS);

  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic              cfg_sel;
  logic [CNT_W-1:0]  cfg_data;

  modport master (output cfg_we, cfg_addr, cfg_sel, cfg_data);
  modport slave  (input  cfg_we, cfg_addr, cfg_sel, cfg_data);

endinterface

// File: rtl/psc_trigger_channel.sv
// One trigger channel: delay/pulse FSM, live and shadow timing registers, sticky overrun flag.
// Define PSC_TRIG_RETRIGGER_EN to let a trigger during DELAY restart the delay instead of flagging an overrun.
module psc_trigger_channel
  import psc_trigger_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DEF_DELAY = 0,
  parameter int DEF_WIDTH = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig_i,
  input  logic             enable_i,
  input  logic             we_delay_i,
  input  logic             we_width_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             miss_clr_i,
  output logic             psc_output_o,
  output logic             busy_o,
  output logic             missed_o
);

`ifdef PSC_TRIG_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] live_delay_q, live_delay_d;
  logic [CNT_W-1:0] live_width_q, live_width_d;
  logic [CNT_W-1:0] shadow_width_q, shadow_width_d;
  logic             missed_q, missed_d;
  logic             psc_q, psc_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic [CNT_W-1:0] eff_width;
  state_e           start_state;
  logic [CNT_W-1:0] start_cnt;

  // The delay is consumed straight into cnt at acceptance, so only the width needs a shadow copy.
  assign accept      = trig_i & enable_i;
  assign eff_width   = (live_width_q == '0) ? CNT_W'(1) : live_width_q;
  assign start_state = (live_delay_q == '0) ? PULSE : DELAY;
  assign start_cnt   = (live_delay_q == '0) ? eff_width - CNT_W'(1) : live_delay_q - CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    shadow_width_d = shadow_width_q;
    missed_d       = missed_q & ~miss_clr_i;
    live_delay_d   = we_delay_i ? wdata_i : live_delay_q;
    live_width_d   = we_width_i ? wdata_i : live_width_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d        = start_state;
          cnt_d          = start_cnt;
          shadow_width_d = eff_width;
        end
      end
      DELAY: begin
        if (accept && RETRIGGER) begin
          state_d        = start_state;
          cnt_d          = start_cnt;
          shadow_width_d = eff_width;
        end else begin
          if (accept) missed_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = PULSE;
            cnt_d   = shadow_width_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      PULSE: begin
        if (accept) missed_d = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    psc_d  = (state_d == PULSE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      live_delay_q   <= CNT_W'(DEF_DELAY);
      live_width_q   <= CNT_W'(DEF_WIDTH);
      shadow_width_q <= CNT_W'(DEF_WIDTH);
      missed_q       <= 1'b0;
      psc_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      live_delay_q   <= live_delay_d;
      live_width_q   <= live_width_d;
      shadow_width_q <= shadow_width_d;
      missed_q       <= missed_d;
      psc_q          <= psc_d;
      busy_q         <= busy_d;
    end
  end

  assign psc_output_o = psc_q;
  assign busy_o       = busy_q;
  assign missed_o     = missed_q;

endmodule

// File: rtl/psc_trigger_bank.sv
// Multi-channel PSC trigger: synchronises the EVR trigger, detects its rising edge and fans it out.
// Retrigger-in-DELAY behaviour is selected by the PSC_TRIG_RETRIGGER_EN macro inside each channel.
module psc_trigger_bank
  import psc_trigger_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEF_DELAY   = 0,
  parameter int DEF_WIDTH   = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                evr_trigger,
  input  logic [CHANNELS-1:0] enable,
  psc_trigger_bank_if.slave   cfg,
  input  logic [CHANNELS-1:0] miss_clr,
  output logic [CHANNELS-1:0] psc_output,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] missed
);

  localparam int ADDR_W = addr_w(CHANNELS);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   trig;
  logic [CHANNELS-1:0]    we_delay, we_width;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], evr_trigger};
  assign edge_d = sync_q[SYNC_STAGES-1];
  assign trig   = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  // Addresses beyond the last channel match nothing and are dropped.
  always_comb begin
    we_delay = '0;
    we_width = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_we && (cfg.cfg_addr == ADDR_W'(i))) begin
        we_delay[i] = (cfg.cfg_sel == CFG_DELAY);
        we_width[i] = (cfg.cfg_sel == CFG_WIDTH);
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    psc_trigger_channel #(
      .CNT_W     (CNT_W),
      .DEF_DELAY (DEF_DELAY),
      .DEF_WIDTH (DEF_WIDTH)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .trig_i       (trig),
      .enable_i     (enable[g]),
      .we_delay_i   (we_delay[g]),
      .we_width_i   (we_width[g]),
      .wdata_i      (cfg.cfg_data),
      .miss_clr_i   (miss_clr[g]),
      .psc_output_o (psc_output[g]),
      .busy_o       (busy[g]),
      .missed_o     (missed[g])
    );
  end

endmodule

// File: tb/tb_psc_trigger_bank.sv
// Directed testbench for psc_trigger_bank (CHANNELS=4, SYNC_STAGES=2, 20-unit clock).
// Expected windows are edge indices counted from the first edge that samples evr_trigger high.
module tb_psc_trigger_bank;
  import psc_trigger_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       evr_trigger;
  logic [3:0] enable;
  logic [3:0] miss_clr;
  logic [3:0] psc_output;
  logic [3:0] busy;
  logic [3:0] missed;

  int checks = 0;
  int errors = 0;

  logic [3:0] h_out  [0:127];
  logic [3:0] h_busy [0:127];
  logic [3:0] h_miss [0:127];

  psc_trigger_bank_if #(.CHANNELS(4), .CNT_W(16)) cfg_if ();

  psc_trigger_bank #(
    .CHANNELS    (4),
    .CNT_W       (16),
    .SYNC_STAGES (2),
    .DEF_DELAY   (0),
    .DEF_WIDTH   (50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .evr_trigger (evr_trigger),
    .enable      (enable),
    .cfg         (cfg_if),
    .miss_clr    (miss_clr),
    .psc_output  (psc_output),
    .busy        (busy),
    .missed      (missed)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic cfg_write(input logic [1:0] addr, input logic sel, input logic [15:0] data);
    @(negedge clk);
    cfg_if.cfg_we   = 1'b1;
    cfg_if.cfg_addr = addr;
    cfg_if.cfg_sel  = sel;
    cfg_if.cfg_data = data;
    @(negedge clk);
    cfg_if.cfg_we   = 1'b0;
  endtask

  task automatic clear_missed();
    @(negedge clk);
    miss_clr = 4'hF;
    @(negedge clk);
    miss_clr = 4'h0;
  endtask

  // Raise evr_trigger so the next edge is edge 0, record outputs after edges 0..n-1.
  // Optional second rising edge at rise2, miss_clr[0] during edge clr_edge, config write at wr_edge.
  task automatic run_edges(input int n, input int rise2, input int clr_edge, input int wr_edge,
                           input logic [1:0] wr_addr, input logic wr_sel, input logic [15:0] wr_data);
    @(negedge clk);
    evr_trigger   = 1'b1;
    miss_clr      = 4'h0;
    cfg_if.cfg_we = 1'b0;
    for (int k = 0; k < n; k++) begin
      int e;
      @(posedge clk);
      @(negedge clk);
      h_out[k]  = psc_output;
      h_busy[k] = busy;
      h_miss[k] = missed;
      e = k + 1;
      evr_trigger     = (e < 6) || (rise2 >= 0 && e >= rise2 && e < rise2 + 6);
      miss_clr        = (e == clr_edge) ? 4'b0001 : 4'b0000;
      cfg_if.cfg_we   = (e == wr_edge);
      cfg_if.cfg_addr = wr_addr;
      cfg_if.cfg_sel  = wr_sel;
      cfg_if.cfg_data = wr_data;
    end
    evr_trigger   = 1'b0;
    miss_clr      = 4'h0;
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    evr_trigger     = 1'b0;
    enable          = 4'h0;
    miss_clr        = 4'h0;
    cfg_if.cfg_we   = 1'b0;
    cfg_if.cfg_addr = '0;
    cfg_if.cfg_sel  = 1'b0;
    cfg_if.cfg_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (psc_output !== 4'h0) begin errors++; $display("FAIL reset psc_output=%b expected 0000", psc_output); end
    checks++; if (busy !== 4'h0)       begin errors++; $display("FAIL reset busy=%b expected 0000", busy); end
    checks++; if (missed !== 4'h0)     begin errors++; $display("FAIL reset missed=%b expected 0000", missed); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (psc_output !== 4'h0) begin errors++; $display("FAIL post_reset psc_output=%b expected 0000", psc_output); end
  endtask

  task automatic test_defaults(input string tag);
    enable = 4'hF;
    run_edges(60, -1, -1, -1, 2'd0, 1'b0, 16'd0);
    for (int k = 0; k < 60; k++) begin
      logic [3:0] exp;
      exp = (k >= 2 && k <= 51) ? 4'hF : 4'h0;
      checks++; if (h_out[k] !== exp)  begin errors++; $display("FAIL %s out edge %0d got %b expected %b", tag, k, h_out[k], exp); end
      checks++; if (h_busy[k] !== exp) begin errors++; $display("FAIL %s busy edge %0d got %b expected %b", tag, k, h_busy[k], exp); end
      checks++; if (h_miss[k] !== 4'h0) begin errors++; $display("FAIL %s missed edge %0d got %b expected 0000", tag, k, h_miss[k]); end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_channel_timing();
    cfg_write(2'd1, CFG_DELAY, 16'd10);
    cfg_write(2'd1, CFG_WIDTH, 16'd3);
    cfg_write(2'd2, CFG_DELAY, 16'd0);
    cfg_write(2'd2, CFG_WIDTH, 16'd1);
    enable = 4'hF;
    run_edges(60, -1, -1, -1, 2'd0, 1'b0, 16'd0);
    for (int k = 0; k < 60; k++) begin
      logic [3:0] exp;
      exp[0] = (k >= 2 && k <= 51);
      exp[1] = (k >= 12 && k <= 14);
      exp[2] = (k == 2);
      exp[3] = (k >= 2 && k <= 51);
      checks++; if (h_out[k] !== exp) begin errors++; $display("FAIL timing out edge %0d got %b expected %b", k, h_out[k], exp); end
      checks++; if (h_busy[k][1] !== (k >= 2 && k <= 14)) begin errors++; $display("FAIL timing busy1 edge %0d got %b", k, h_busy[k][1]); end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_overrun();
    cfg_write(2'd0, CFG_WIDTH, 16'd100);
    enable = 4'b0001;
    run_edges(120, 40, -1, -1, 2'd0, 1'b0, 16'd0);
    for (int k = 0; k < 120; k++) begin
      checks++; if (h_out[k][0] !== (k >= 2 && k <= 101)) begin errors++; $display("FAIL overrun out0 edge %0d got %b", k, h_out[k][0]); end
      checks++; if (h_miss[k][0] !== (k >= 42)) begin errors++; $display("FAIL overrun missed0 edge %0d got %b expected %b", k, h_miss[k][0], k >= 42); end
    end
    @(negedge clk);
    miss_clr = 4'b0001;
    @(negedge clk);
    miss_clr = 4'b0000;
    checks++; if (missed[0] !== 1'b0) begin errors++; $display("FAIL miss_clr missed0=%b expected 0", missed[0]); end

    run_edges(120, 40, 42, -1, 2'd0, 1'b0, 16'd0);
    checks++; if (h_miss[41][0] !== 1'b0) begin errors++; $display("FAIL set_clr missed0 edge 41 got %b expected 0", h_miss[41][0]); end
    checks++; if (h_miss[42][0] !== 1'b1) begin errors++; $display("FAIL set_clr missed0 edge 42 got %b expected 1", h_miss[42][0]); end
    checks++; if (h_miss[119][0] !== 1'b1) begin errors++; $display("FAIL set_clr missed0 edge 119 got %b expected 1", h_miss[119][0]); end
    checks++; if (h_out[101][0] !== 1'b1) begin errors++; $display("FAIL set_clr out0 edge 101 got %b expected 1", h_out[101][0]); end
    checks++; if (h_out[102][0] !== 1'b0) begin errors++; $display("FAIL set_clr out0 edge 102 got %b expected 0", h_out[102][0]); end
    clear_missed();
    checks++; if (missed !== 4'h0) begin errors++; $display("FAIL overrun_clear missed=%b expected 0000", missed); end
  endtask

  task automatic test_retrigger();
    int lo, hi;
    cfg_write(2'd3, CFG_DELAY, 16'd20);
    enable = 4'b1000;
    run_edges(100, 10, -1, -1, 2'd0, 1'b0, 16'd0);
`ifdef PSC_TRIG_RETRIGGER_EN
    lo = 32; hi = 81;
`else
    lo = 22; hi = 71;
`endif
    for (int k = 0; k < 100; k++) begin
      logic exp_miss;
`ifdef PSC_TRIG_RETRIGGER_EN
      exp_miss = 1'b0;
`else
      exp_miss = (k >= 12);
`endif
      checks++; if (h_out[k][3] !== (k >= lo && k <= hi)) begin errors++; $display("FAIL retrigger out3 edge %0d got %b", k, h_out[k][3]); end
      checks++; if (h_busy[k][3] !== (k >= 2 && k <= hi)) begin errors++; $display("FAIL retrigger busy3 edge %0d got %b", k, h_busy[k][3]); end
      checks++; if (h_miss[k][3] !== exp_miss) begin errors++; $display("FAIL retrigger missed3 edge %0d got %b expected %b", k, h_miss[k][3], exp_miss); end
    end
    clear_missed();
  endtask

  task automatic test_enable_config();
    cfg_write(2'd0, CFG_WIDTH, 16'd0);
    enable = 4'b1011;
    // Width of ch1 rewritten to 7 at edge 6 while it sits in DELAY.
    run_edges(80, -1, -1, 6, 2'd1, CFG_WIDTH, 16'd7);
    for (int k = 0; k < 80; k++) begin
      logic [3:0] exp;
      exp[0] = (k == 2);
      exp[1] = (k >= 12 && k <= 14);
      exp[2] = 1'b0;
      exp[3] = (k >= 22 && k <= 71);
      checks++; if (h_out[k] !== exp) begin errors++; $display("FAIL enable_cfg out edge %0d got %b expected %b", k, h_out[k], exp); end
      checks++; if (h_busy[k][2] !== 1'b0) begin errors++; $display("FAIL enable_cfg busy2 edge %0d got %b expected 0", k, h_busy[k][2]); end
      checks++; if (h_miss[k] !== 4'h0) begin errors++; $display("FAIL enable_cfg missed edge %0d got %b expected 0000", k, h_miss[k]); end
    end
    repeat (5) @(negedge clk);
    run_edges(80, -1, -1, -1, 2'd0, 1'b0, 16'd0);
    for (int k = 0; k < 80; k++) begin
      checks++; if (h_out[k][1] !== (k >= 12 && k <= 18)) begin errors++; $display("FAIL new_width out1 edge %0d got %b", k, h_out[k][1]); end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_sequence();
    enable = 4'hF;
    run_edges(30, -1, -1, -1, 2'd0, 1'b0, 16'd0);
    checks++; if (h_out[29] !== 4'b1000) begin errors++; $display("FAIL mid_seq out edge 29 got %b expected 1000", h_out[29]); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (psc_output !== 4'h0) begin errors++; $display("FAIL mid_reset psc_output=%b expected 0000", psc_output); end
    checks++; if (busy !== 4'h0)       begin errors++; $display("FAIL mid_reset busy=%b expected 0000", busy); end
    checks++; if (missed !== 4'h0)     begin errors++; $display("FAIL mid_reset missed=%b expected 0000", missed); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_defaults("after_reset");
  endtask

  initial begin
    test_reset();
    test_defaults("defaults");
    test_channel_timing();
    test_overrun();
    test_retrigger();
    test_enable_config();
    test_reset_mid_sequence();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psc_trigger_bank.md
# psc_trigger_bank

Multi-channel successor to the single-output power-supply trigger. It takes one asynchronous event-receiver trigger and drives CHANNELS independent trigger pulses toward power-supply controllers. Each channel has its own programmable delay, pulse width and enable, and keeps a sticky overrun flag. It sits between the EVR trigger input and the PSC output pins, and is configured through a simple register-write port.

## Interface
- CHANNELS, 4: number of output channels (1..16).
- CNT_W, 16: width of the delay and width counters and of cfg_data.
- SYNC_STAGES, 2: synchroniser depth for evr_trigger (≥2).
- DEF_DELAY, 0: delay value loaded at reset, in clk cycles.
- DEF_WIDTH, 50: pulse-width value loaded at reset, in clk cycles.

- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high.
- evr_trigger  in  1  asynchronous EVR trigger; acted on at its rising edge.
- enable  in  CHANNELS  per-channel arm; a low bit makes that channel ignore triggers.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  $clog2(CHANNELS) (min 1)  channel index.
- cfg_sel  in  1  register select: 0 = delay, 1 = width.
- cfg_data  in  CNT_W  value to write.
- miss_clr  in  CHANNELS  per-channel clear for the missed flags.
- psc_output  out  CHANNELS  trigger pulses (registered).
- busy  out  CHANNELS  channel is in DELAY or PULSE.
- missed  out  CHANNELS  sticky flag: a trigger arrived while the channel was busy.

## Operation
- Trigger capture:
  - evr_trigger passes through a SYNC_STAGES flop chain, then a registered rising-edge detector produces a 1-cycle `trig` pulse.
  - A level held high gives exactly one `trig`.
- Configuration:
  - A cfg_we write updates the live delay or width register of the channel at cfg_addr on the next edge.
  - A cfg_addr ≥ CHANNELS is ignored.
  - A stored width of 0 is treated as 1.
  - When a trigger is accepted, the live values are copied into shadow registers. Writes made mid-sequence therefore apply from the next trigger onward.
- Per-channel FSM, states IDLE, DELAY, PULSE:
  - IDLE + trig + enable, delay D > 0: go to DELAY, cnt = D−1.
  - IDLE + trig + enable, D = 0: go straight to PULSE, cnt = W−1.
  - DELAY: when cnt = 0, go to PULSE with cnt = W−1; otherwise decrement cnt.
  - PULSE: psc_output = 1. When cnt = 0, go to IDLE; otherwise decrement cnt.
  - IDLE + trig with enable low: no action and no missed flag.
- Trigger while busy:
  - In PULSE, including its last cycle: the trigger is ignored and missed is set.
  - In DELAY: behaviour depends on the configuration macro (see Configuration).
- Enable deasserted mid-sequence: the current sequence completes normally.
- missed bit: set on overrun, cleared by miss_clr. If set and clear happen in the same cycle, set wins.
- Reset values:
  - All FSMs in IDLE; psc_output, busy and missed all 0.
  - Synchroniser and edge-detector registers 0.
  - Live delay = DEF_DELAY, live width = DEF_WIDTH.
  - Reset asserted mid-sequence aborts the sequence: the output is 0 after the next edge.

## Timing
- Take edge 0 as the first clk edge that samples evr_trigger high. The trigger is accepted at edge SYNC_STAGES.
- psc_output rises at edge SYNC_STAGES + D and stays high for exactly W cycles.
- With SYNC_STAGES = 2 and D = 0, the output rises at edge 2, i.e. 2 cycles of latency.
- busy goes high at the accepting edge and drops on the same edge psc_output drops.
- All channels see the same `trig`. Channels with equal D and W produce identical, cycle-aligned outputs.
- Counters never wrap. The maximum sequence length is (2^CNT_W − 1) delay cycles plus 2^CNT_W − 1 pulse cycles.

## Configuration
- PSC_TRIG_RETRIGGER_EN defined:
  - A trigger while in DELAY re-latches the shadow registers and restarts the delay (cnt = D−1, or straight to PULSE if D = 0).
  - missed is not set.
- Not defined: a trigger in DELAY is ignored and sets missed.
- Behaviour in PULSE is identical either way.

## Structure
- psc_trigger_pkg holds:
  - the state enum (IDLE, DELAY, PULSE);
  - the cfg_sel constants CFG_DELAY = 0 and CFG_WIDTH = 1.
- Sub-module psc_trigger_channel contains one FSM, its counter, the shadow and live registers, and the missed logic. It is instantiated CHANNELS times by a generate loop.
- The top level contains only the synchroniser, the edge detector and config address decode.

## Test plan
All scenarios use CHANNELS=4, SYNC_STAGES=2, 20 ns clk.
- Reset defaults: release reset, raise evr_trigger with enable=4'hF → all four outputs rise at edge 2 and stay high for 50 cycles. missed stays 0.
- Per-channel timing: ch1 D=10 W=3, ch2 D=0 W=1 → ch1 high over edges 12–14, ch2 high at edge 2 only.
- Overrun on ch0 (D=0 W=100), second rising edge 40 cycles later:
  - ch0 pulse stays exactly 100 cycles and missed[0] = 1;
  - miss_clr[0] → missed[0] = 0;
  - miss_clr and a new overrun in the same cycle → missed stays 1.
- Retrigger on ch3 (D=20), second edge 10 cycles after the first:
  - with PSC_TRIG_RETRIGGER_EN, the pulse starts 20 cycles after the second acceptance and missed = 0;
  - without it, timing follows the first trigger and missed[3] = 1.
- Enable and config changes: enable[2]=0 with a trigger → no pulse, missed 0. Writing width=0 gives a 1-cycle pulse. A write mid-DELAY does not affect the running sequence.
- Reset mid-sequence: assert reset during PULSE → psc_output and busy are 0 after the next edge, and registers return to their defaults.
